gate_sequencer: RTL and testbench
=================================

GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 Parameter N, default 2, number of qubits; the state vector has 2**N complex entries.
REQ-002 Parameter MAX_GATES, default 16, depth of the gate program memory.
REQ-003 Parameter AW, default 4, equal to log2(MAX_GATES), the gate address width.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles spent waiting for gate_vld or mult_done.
REQ-005 Port clk, input, 1 bit, the single clock; all logic SHALL be clocked on posedge clk.
REQ-006 Port reset, input, 1 bit, asynchronous active-low reset.
REQ-007 Port start, input, 1 bit, request to run a circuit.
REQ-008 Port num_gates, input, AW+1 bits, number of gates to apply; sampled only when start is accepted.
REQ-009 Port abort, input, 1 bit, synchronous cancel of the running circuit.
REQ-010 Port gate_rd, output, 1 bit, one-cycle read strobe to the gate memory.
REQ-011 Port gate_addr, output, AW bits, gate memory address, qualified by gate_rd.
REQ-012 Port gate_vld, input, 1 bit, gate matrix is loaded into the multiplier.
REQ-013 Port mult_go, output, 1 bit, one-cycle pulse that starts the gate-state multiply.
REQ-014 Port mult_done, input, 1 bit, multiplier output state is valid.
REQ-015 Port state_wb, output, 1 bit, one-cycle pulse that copies the output state into the state register.
REQ-016 Port busy, output, 1 bit, high in every state except IDLE.
REQ-017 Port done, output, 1 bit, one-cycle pulse when the circuit completes normally.
REQ-018 Port err, output, 1 bit, sticky error flag.
REQ-019 Port gates_done, output, AW+1 bits, count of gates applied in the current or last run.

Function
REQ-020 The block SHALL register all outputs and implement states IDLE, FETCH, WAIT_GATE, MULT, WAIT_MULT, WRITEBACK and FINISH.
REQ-021 IDLE behaviour:
- A valid start is start=1 with 1<=num_gates<=MAX_GATES.
- On a valid start: latch num_gates, clear gates_done, the address index and err; go to FETCH.
- On start with num_gates=0 or num_gates>MAX_GATES: set err=1, stay in IDLE, no done pulse.
REQ-022 FETCH SHALL assert gate_rd for exactly one cycle with gate_addr=index, then go to WAIT_GATE.
REQ-023 WAIT_GATE SHALL go to MULT in the cycle after gate_vld=1 is sampled.
REQ-024 MULT SHALL assert mult_go for exactly one cycle, then go to WAIT_MULT.
REQ-025 WAIT_MULT SHALL go to WRITEBACK in the cycle after mult_done=1 is sampled.
REQ-026 WRITEBACK behaviour:
- Assert state_wb for one cycle and increment gates_done and the index.
- Go to FINISH if the new gates_done equals the latched count; otherwise go to FETCH.
REQ-027 FINISH SHALL assert done for one cycle, then return to IDLE.
REQ-028 Minimum per-gate cost is 5 cycles (FETCH, WAIT_GATE, MULT, WAIT_MULT, WRITEBACK) when gate_vld and mult_done return on the first wait cycle.
- A K-gate run SHALL therefore assert done 5K+1 cycles after the start-accept edge.
REQ-029 Wait-state timeout:
- A wait counter SHALL clear on entry to WAIT_GATE and WAIT_MULT.
- If it reaches TIMEOUT without the awaited input, set err=1 and go to IDLE with no done pulse.
REQ-030 Abort:
- abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done, no further strobes, and err unchanged.
- abort SHALL take priority over every other transition; abort in IDLE has no effect.
REQ-031 start while busy SHALL be ignored and SHALL NOT change the latched count.
REQ-032 gate_vld and mult_done outside their own wait states SHALL be ignored.
REQ-033 gate_addr SHALL equal the index truncated to AW bits, so a run of MAX_GATES gates uses addresses 0..MAX_GATES-1 with no wrap.
REQ-034 gates_done and err SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-035 When reset=0, the block SHALL asynchronously force state=IDLE and clear every output (gate_rd, gate_addr, mult_go, state_wb, busy, done, err, gates_done), the index, the latched count and the wait counter.
REQ-036 Reset asserted mid-run SHALL abandon the run with no done pulse, and the first valid start after reset release SHALL run normally.

Verification
REQ-037 start with num_gates=3, zero-wait responders -> gate_addr 0,1,2 issued; 3 state_wb pulses; done exactly 16 cycles after the accept edge; gates_done=3; err=0.
REQ-038 start with num_gates=0, then again with 17 -> err=1 each time, busy stays 0, no gate_rd, no done.
REQ-039 num_gates=2 with gate_vld withheld -> err=1 after 255 cycles in WAIT_GATE, return to IDLE, no mult_go, no done.
REQ-040 num_gates=4 with abort asserted in WAIT_MULT of gate 2 -> IDLE next cycle; gates_done=1; no state_wb, no done.
REQ-041 start pulsed during a running 2-gate job with num_gates=5 -> ignored; run completes with gates_done=2.
REQ-042 reset driven low during WRITEBACK -> all outputs 0 immediately; after release, num_gates=16 runs addresses 0..15 and done fires after 81 cycles.

Source files
------------

// File: rtl/gate_sequencer.sv
// Control sequencer for a state-vector quantum simulator: walks the gate program,
// handshakes with the gate loader and the multiplier, and writes back each result.
module gate_sequencer #(
    parameter int N         = 2,
    parameter int MAX_GATES = 16,
    parameter int AW        = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   num_gates,
    input  logic          abort,
    output logic          gate_rd,
    output logic [AW-1:0] gate_addr,
    input  logic          gate_vld,
    output logic          mult_go,
    input  logic          mult_done,
    output logic          state_wb,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   gates_done
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   MAX_CNT  = (AW + 1)'(MAX_GATES);
    localparam logic [TW-1:0] WAIT_END = TW'(TIMEOUT - 1);

    if (N < 1 || (1 << AW) != MAX_GATES) begin : g_param_check
        $error("gate_sequencer: N must be >= 1 and MAX_GATES must equal 2**AW");
    end

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_GATE, MULT, WAIT_MULT, WRITEBACK, FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   idx_q, idx_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [AW:0]   gates_done_q, gates_done_d;
    logic [AW-1:0] gate_addr_q, gate_addr_d;
    logic          gate_rd_q, gate_rd_d;
    logic          mult_go_q, mult_go_d;
    logic          state_wb_q, state_wb_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW:0]   gd_inc;

    // Strobes decode the current state and appear one cycle later, so a
    // K-gate run reports done 5K+1 cycles after the accepting edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        gates_done_d = gates_done_q;
        gate_addr_d  = gate_addr_q;
        err_d        = err_q;
        gate_rd_d    = 1'b0;
        mult_go_d    = 1'b0;
        state_wb_d   = 1'b0;
        done_d       = 1'b0;
        gd_inc       = gates_done_q + (AW + 1)'(1);

        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_gates != '0 && num_gates <= MAX_CNT) begin
                            cnt_d        = num_gates;
                            gates_done_d = '0;
                            idx_d        = '0;
                            err_d        = 1'b0;
                            state_d      = FETCH;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    gate_rd_d   = 1'b1;
                    gate_addr_d = idx_q[AW-1:0];
                    wait_d      = '0;
                    state_d     = WAIT_GATE;
                end
                WAIT_GATE: begin
                    if (gate_vld) begin
                        state_d = MULT;
                    end else if (wait_q >= WAIT_END) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wait_d = wait_q + TW'(1);
                    end
                end
                MULT: begin
                    mult_go_d = 1'b1;
                    wait_d    = '0;
                    state_d   = WAIT_MULT;
                end
                WAIT_MULT: begin
                    if (mult_done) begin
                        state_d = WRITEBACK;
                    end else if (wait_q >= WAIT_END) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wait_d = wait_q + TW'(1);
                    end
                end
                WRITEBACK: begin
                    state_wb_d   = 1'b1;
                    gates_done_d = gd_inc;
                    idx_d        = idx_q + (AW + 1)'(1);
                    state_d      = (gd_inc == cnt_q) ? FINISH : FETCH;
                end
                FINISH: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            wait_q       <= '0;
            gates_done_q <= '0;
            gate_addr_q  <= '0;
            gate_rd_q    <= 1'b0;
            mult_go_q    <= 1'b0;
            state_wb_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            gates_done_q <= gates_done_d;
            gate_addr_q  <= gate_addr_d;
            gate_rd_q    <= gate_rd_d;
            mult_go_q    <= mult_go_d;
            state_wb_q   <= state_wb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign gate_rd    = gate_rd_q;
    assign gate_addr  = gate_addr_q;
    assign mult_go    = mult_go_q;
    assign state_wb   = state_wb_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign gates_done = gates_done_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer: a table of start requests with hand-computed
// results, then hand-written timeout, abort, busy-start and mid-run reset sequences.
module tb_gate_sequencer;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   num_gates = '0;
    logic          abort = 1'b0;
    logic          gate_rd;
    logic [AW-1:0] gate_addr;
    logic          gate_vld = 1'b0;
    logic          mult_go;
    logic          mult_done = 1'b0;
    logic          state_wb;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   gates_done;

    always #5 clk = ~clk;

    gate_sequencer #(.N(2), .MAX_GATES(16), .AW(AW), .TIMEOUT(255)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .num_gates  (num_gates),
        .abort      (abort),
        .gate_rd    (gate_rd),
        .gate_addr  (gate_addr),
        .gate_vld   (gate_vld),
        .mult_go    (mult_go),
        .mult_done  (mult_done),
        .state_wb   (state_wb),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .gates_done (gates_done)
    );

    // Zero-wait responders plus strobe counters, all on the falling edge.
    logic          vld_en = 1'b1;
    int            rd_cnt = 0, wb_cnt = 0, go_cnt = 0, done_cnt = 0;
    logic [AW-1:0] addr_log [512];

    always @(negedge clk) begin
        gate_vld  = gate_rd & vld_en;
        mult_done = mult_go;
        if (gate_rd) begin
            if (rd_cnt < 512) addr_log[rd_cnt] = gate_addr;
            rd_cnt++;
        end
        if (state_wb) wb_cnt++;
        if (mult_go)  go_cnt++;
        if (done)     done_cnt++;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input int n);
        num_gates = n[AW:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = c;
                break;
            end
        end
    endtask

    typedef struct {
        int num;
        bit valid;
        int exp_gd;
        int exp_cyc;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_rd, b_wb, b_go, b_done, cyc;

        vecs[0] = '{num: 3,  valid: 1'b1, exp_gd: 3,  exp_cyc: 16};
        vecs[1] = '{num: 0,  valid: 1'b0, exp_gd: 3,  exp_cyc: 0};
        vecs[2] = '{num: 17, valid: 1'b0, exp_gd: 3,  exp_cyc: 0};
        vecs[3] = '{num: 1,  valid: 1'b1, exp_gd: 1,  exp_cyc: 6};
        vecs[4] = '{num: 31, valid: 1'b0, exp_gd: 1,  exp_cyc: 0};
        vecs[5] = '{num: 16, valid: 1'b1, exp_gd: 16, exp_cyc: 81};
        vecs[6] = '{num: 2,  valid: 1'b1, exp_gd: 2,  exp_cyc: 11};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset err", err, 0);
        check("reset gates_done", gates_done, 0);
        check("reset strobes", {gate_rd, mult_go, state_wb, done}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            b_rd = rd_cnt; b_wb = wb_cnt; b_done = done_cnt;
            launch(vecs[i].num);
            check($sformatf("v%0d busy after start", i), busy, vecs[i].valid);
            check($sformatf("v%0d err after start", i), err, !vecs[i].valid);
            if (vecs[i].valid) begin
                wait_done(200, cyc);
                check($sformatf("v%0d done latency", i), cyc, vecs[i].exp_cyc);
                repeat (2) @(posedge clk);
                #1;
                check($sformatf("v%0d busy at end", i), busy, 0);
                check($sformatf("v%0d gates_done", i), gates_done, vecs[i].exp_gd);
                check($sformatf("v%0d err at end", i), err, 0);
                check($sformatf("v%0d gate_rd count", i), rd_cnt - b_rd, vecs[i].num);
                check($sformatf("v%0d state_wb count", i), wb_cnt - b_wb, vecs[i].num);
                check($sformatf("v%0d done count", i), done_cnt - b_done, 1);
                for (int j = 0; j < vecs[i].num; j++)
                    check($sformatf("v%0d gate_addr[%0d]", i, j), addr_log[b_rd + j], j);
            end else begin
                repeat (8) @(posedge clk);
                #1;
                check($sformatf("v%0d busy stays low", i), busy, 0);
                check($sformatf("v%0d err sticky", i), err, 1);
                check($sformatf("v%0d gates_done held", i), gates_done, vecs[i].exp_gd);
                check($sformatf("v%0d no gate_rd", i), rd_cnt - b_rd, 0);
                check($sformatf("v%0d no done", i), done_cnt - b_done, 0);
            end
        end

        // gate_vld withheld: timeout after 255 cycles in WAIT_GATE
        vld_en = 1'b0;
        b_go = go_cnt; b_done = done_cnt;
        launch(2);
        repeat (255) @(posedge clk);
        #1;
        check("timeout busy before limit", busy, 1);
        check("timeout err before limit", err, 0);
        @(posedge clk); #1;
        check("timeout busy", busy, 0);
        check("timeout err", err, 1);
        repeat (4) @(posedge clk);
        #1;
        check("timeout no mult_go", go_cnt - b_go, 0);
        check("timeout no done", done_cnt - b_done, 0);
        vld_en = 1'b1;

        // abort while gate 2 sits in WAIT_MULT
        b_rd = rd_cnt; b_wb = wb_cnt; b_go = go_cnt; b_done = done_cnt;
        launch(4);
        repeat (8) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort gates_done", gates_done, 1);
        repeat (6) @(posedge clk);
        #1;
        check("abort state_wb count", wb_cnt - b_wb, 1);
        check("abort mult_go count", go_cnt - b_go, 2);
        check("abort gate_rd count", rd_cnt - b_rd, 2);
        check("abort no done", done_cnt - b_done, 0);
        check("abort err", err, 0);

        // abort in IDLE is harmless
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle abort gates_done", gates_done, 1);

        // start with num_gates=5 while a 2-gate run is busy
        b_rd = rd_cnt;
        launch(2);
        repeat (3) @(posedge clk);
        #1;
        num_gates = 5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, cyc);
        check("busy start done latency", cyc, 7);
        repeat (2) @(posedge clk);
        #1;
        check("busy start gates_done", gates_done, 2);
        check("busy start gate_rd count", rd_cnt - b_rd, 2);
        check("busy start idle", busy, 0);

        // reset during WRITEBACK of gate 2, then a full 16-gate run
        b_done = done_cnt;
        launch(3);
        repeat (9) @(posedge clk);
        #1;
        check("pre-reset gate_addr", gate_addr, 1);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", busy, 0);
        check("mid reset gates_done", gates_done, 0);
        check("mid reset gate_addr", gate_addr, 0);
        check("mid reset flags", {gate_rd, mult_go, state_wb, done, err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("reset run no done", done_cnt - b_done, 0);
        b_rd = rd_cnt;
        launch(16);
        wait_done(200, cyc);
        check("post-reset done latency", cyc, 81);
        repeat (2) @(posedge clk);
        #1;
        check("post-reset gates_done", gates_done, 16);
        check("post-reset gate_rd count", rd_cnt - b_rd, 16);
        for (int j = 0; j < 16; j++)
            check($sformatf("post-reset gate_addr[%0d]", j), addr_log[b_rd + j], j);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
